// File: rtl/fifo_uart_tx_pkg.sv
// Shared types and counter-width helpers for the FIFO-fed UART transmitter.
package fifo_uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    // Width of a counter holding 0..n-1, never narrower than one bit.
    function automatic int ctr_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_uart_tx_if.sv
// Read-side handshake of the bus FIFO: the FIFO presents a word, the consumer pops it.
interface fifo_uart_tx_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  FIFO_READY;
    logic [DATA_WIDTH-1:0] FIFO_DATA;
    logic                  FIFO_ACK;

    modport master (output FIFO_READY, output FIFO_DATA, input FIFO_ACK);
    modport slave  (input FIFO_READY, input FIFO_DATA, output FIFO_ACK);
endinterface

// File: rtl/fifo_uart_tx_baud_tick.sv
// Loadable bit-period down-counter; tick_o is high while the count sits at zero.
module baud_tick #(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             tick_o
);
    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == '0);
endmodule

// File: rtl/fifo_uart_tx.sv
// Pops words from the TX FIFO and serialises each as a UART frame on TX.
module fifo_uart_tx
    import fifo_uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic          CLK,
    input  logic          RESET_N,
    fifo_uart_tx_if.slave fifo,
    input  logic          ENABLE,
    output logic          TX,
    output logic          BUSY
);
    localparam int CNT_W = ctr_w(CLKS_PER_BIT);
    localparam int IDX_N = (DATA_WIDTH > STOP_BITS) ? DATA_WIDTH : STOP_BITS;
    localparam int IDX_W = ctr_w(IDX_N);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_WIDTH - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  par_q, par_d;
    logic                  tx_q, tx_d;
    logic                  ack_q, ack_d;
    logic                  busy_q, busy_d;
    logic                  start;
    logic                  tick;
    logic                  load;

    // Every bit period ends on tick; the counter reloads unless the frame is over.
    assign load = start | ((state_q != IDLE) && tick && (state_d != IDLE));

    baud_tick #(.WIDTH(CNT_W)) u_baud (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .load_i     (load),
        .load_val_i (BIT_LAST),
        .tick_o     (tick)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            idx_q   <= '0;
            tx_q    <= 1'b1;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
        end
    end

    always_ff @(posedge CLK) begin
        shift_q <= shift_d;
        par_q   <= par_d;
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        par_d   = par_q;
        start   = 1'b0;
        case (state_q)
            IDLE:   start = ENABLE & fifo.FIFO_READY;
            START:  if (tick) state_d = DATA;
            DATA: begin
                if (tick) begin
                    if (idx_q == DATA_LAST) begin
                        idx_d   = '0;
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        shift_d = shift_q >> 1;
                    end
                end
            end
            PARITY: if (tick) state_d = STOP;
            STOP: begin
                if (tick) begin
                    if (idx_q == STOP_LAST) begin
                        idx_d   = '0;
                        state_d = IDLE;
                        start   = ENABLE & fifo.FIFO_READY;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // A new word can be taken from IDLE or straight out of the last stop bit.
        if (start) begin
            state_d = START;
            shift_d = fifo.FIFO_DATA;
            par_d   = (^fifo.FIFO_DATA) ^ 1'(PARITY_ODD);
        end
    end

    // Outputs are decoded from the next state so they register on the same edge.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = par_q;
            default: tx_d = 1'b1;
        endcase
        ack_d  = start;
        busy_d = (state_d != IDLE);
    end

    assign TX            = tx_q;
    assign BUSY          = busy_q;
    assign fifo.FIFO_ACK = ack_q;
endmodule
